// File: rtl/button_event_arbiter.sv
// button_event_arbiter: latches button rising edges and serialises them as single events,
// round-robin over a valid/ready handshake with a programmable idle gap between events.
module button_event_arbiter #(
   parameter int NUM_BTNS   = 7,
   parameter int ID_WIDTH   = 3,
   parameter int GAP_CYCLES = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_BTNS-1:0] btn_in,
   input  logic                evt_ready,
   input  logic                overrun_clr,
   output logic                evt_valid,
   output logic [ID_WIDTH-1:0] evt_id,
   output logic [NUM_BTNS-1:0] pending,
   output logic                overrun
);
   localparam logic [7:0] GAP_LOAD = GAP_CYCLES == 0 ? 8'd0 : 8'(GAP_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;
   state_t state, state_nxt;
   logic [NUM_BTNS-1:0] btn_q, rise, grant_vec;
   logic [ID_WIDTH-1:0] last_grant, winner;
   logic [ID_WIDTH:0] idx;
   logic [7:0] gap_cnt;
   logic grant, handshake;
   assign rise = btn_in & ~btn_q;
   // scanning downward lets the nearest set bit after last_grant overwrite farther ones
   always_comb begin
      winner = '0;
      idx = '0;
      for (int k = NUM_BTNS; k >= 1; k--) begin
         idx = {1'b0, last_grant} + (ID_WIDTH+1)'(k);
         idx = idx >= (ID_WIDTH+1)'(NUM_BTNS) ? idx - (ID_WIDTH+1)'(NUM_BTNS) : idx;
         winner = pending[idx[ID_WIDTH-1:0]] ? idx[ID_WIDTH-1:0] : winner;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = |pending ? OFFER : IDLE;
         OFFER:   state_nxt = evt_ready ? (GAP_CYCLES == 0 ? IDLE : GAP) : OFFER;
         GAP:     state_nxt = gap_cnt == 8'd0 ? IDLE : GAP;
         default: state_nxt = IDLE;
      endcase
   end
   always_comb begin
      evt_valid = state == OFFER;
      grant     = state == IDLE && |pending;
      handshake = evt_valid && evt_ready;
      grant_vec = grant ? NUM_BTNS'(1) << winner : '0;
   end
   // a rise on the bit being granted re-arms it rather than counting as an overrun
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_q      <= '0;
         pending    <= '0;
         overrun    <= 1'b0;
         last_grant <= ID_WIDTH'(NUM_BTNS - 1);
         evt_id     <= '0;
         gap_cnt    <= '0;
      end else begin
         btn_q      <= btn_in;
         pending    <= (pending & ~grant_vec) | rise;
         overrun    <= |(rise & pending & ~grant_vec) ? 1'b1 : overrun_clr ? 1'b0 : overrun;
         last_grant <= grant ? winner : last_grant;
         evt_id     <= grant ? winner : evt_id;
         gap_cnt    <= handshake ? GAP_LOAD : (state == GAP && gap_cnt != 8'd0) ? gap_cnt - 8'd1 : gap_cnt;
      end
   end
endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: directed scenarios against hand-computed event order and timing.
module tb_button_event_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [6:0] btn_in = '0;
   logic evt_ready = 1'b0;
   logic overrun_clr = 1'b0;
   logic evt_valid;
   logic [2:0] evt_id;
   logic [6:0] pending;
   logic overrun;
   int tests = 0;
   int fails = 0;
   button_event_arbiter #(.NUM_BTNS(7), .ID_WIDTH(3), .GAP_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .btn_in(btn_in), .evt_ready(evt_ready), .overrun_clr(overrun_clr),
      .evt_valid(evt_valid), .evt_id(evt_id), .pending(pending), .overrun(overrun)
   );
   always #5 clk = ~clk;
   task automatic do_reset;
      reset = 1'b1;
      btn_in = '0;
      evt_ready = 1'b0;
      overrun_clr = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask
   task automatic test_reset;
      reset = 1'b1;
      @(negedge clk);
      tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
      tests++; if (evt_id !== 3'd0) begin fails++; $display("FAIL reset_id: got %0d want 0", evt_id); end
      tests++; if (pending !== 7'd0) begin fails++; $display("FAIL reset_pending: got %b want 0000000", pending); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
   endtask
   task automatic test_single;
      do_reset();
      btn_in = 7'b0000100;
      evt_ready = 1'b1;
      @(negedge clk);
      btn_in = '0;
      tests++; if (pending !== 7'b0000100 || evt_valid !== 1'b0) begin fails++; $display("FAIL single_latch: got pending=%b valid=%b want 0000100 0", pending, evt_valid); end
      @(negedge clk);
      tests++; if (evt_valid !== 1'b1 || evt_id !== 3'd2) begin fails++; $display("FAIL single_offer: got valid=%b id=%0d want 1 2", evt_valid, evt_id); end
      tests++; if (pending !== 7'd0) begin fails++; $display("FAIL single_cleared: got %b want 0000000", pending); end
      @(negedge clk);
      tests++; if (evt_valid !== 1'b0) begin fails++; $display("FAIL single_pulse: got %b want 0", evt_valid); end
      repeat (6) @(negedge clk);
   endtask
   task automatic test_order;
      int n, prev;
      logic [2:0] exp_id;
      do_reset();
      btn_in = 7'b0010011;
      evt_ready = 1'b1;
      @(negedge clk);
      btn_in = '0;
      n = 0;
      prev = 0;
      for (int t = 0; t < 40 && n < 3; t++) begin
         @(negedge clk);
         if (evt_valid) begin
            exp_id = n == 0 ? 3'd0 : n == 1 ? 3'd1 : 3'd4;
            tests++; if (evt_id !== exp_id) begin fails++; $display("FAIL order_id%0d: got %0d want %0d", n, evt_id, exp_id); end
            if (n > 0) begin
               tests++; if (t - prev !== 6) begin fails++; $display("FAIL order_spacing%0d: got %0d want 6", n, t - prev); end
            end
            prev = t;
            n++;
         end
      end
      tests++; if (n !== 3) begin fails++; $display("FAIL order_count: got %0d want 3", n); end
   endtask
   task automatic test_wrap;
      int n;
      logic [2:0] exp_id;
      do_reset();
      btn_in = 7'b0001000;
      @(negedge clk);
      btn_in = '0;
      @(negedge clk);
      btn_in = 7'b0100010;
      @(negedge clk);
      btn_in = '0;
      tests++; if (evt_id !== 3'd3 || pending !== 7'b0100010) begin fails++; $display("FAIL wrap_setup: got id=%0d pending=%b want 3 0100010", evt_id, pending); end
      evt_ready = 1'b1;
      n = 0;
      for (int t = 0; t < 40 && n < 2; t++) begin
         @(negedge clk);
         if (evt_valid) begin
            exp_id = n == 0 ? 3'd5 : 3'd1;
            tests++; if (evt_id !== exp_id) begin fails++; $display("FAIL wrap_id%0d: got %0d want %0d", n, evt_id, exp_id); end
            n++;
         end
      end
      tests++; if (n !== 2) begin fails++; $display("FAIL wrap_count: got %0d want 2", n); end
   endtask
   task automatic test_back_pressure;
      int n;
      do_reset();
      btn_in = 7'b1000000;
      @(negedge clk);
      btn_in = '0;
      @(negedge clk);
      for (int c = 0; c < 20; c++) begin
         btn_in = (c == 5 || c == 10) ? 7'b1000000 : 7'b0;
         @(negedge clk);
         tests++; if (evt_valid !== 1'b1 || evt_id !== 3'd6) begin fails++; $display("FAIL hold_c%0d: got valid=%b id=%0d want 1 6", c, evt_valid, evt_id); end
         if (c == 5) begin
            tests++; if (pending !== 7'b1000000 || overrun !== 1'b0) begin fails++; $display("FAIL second_press: got pending=%b overrun=%b want 1000000 0", pending, overrun); end
         end
         if (c == 10) begin
            tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL third_press_overrun: got %b want 1", overrun); end
         end
      end
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_clr: got %b want 0", overrun); end
      evt_ready = 1'b1;
      @(negedge clk);
      n = 0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (evt_valid) begin
            n++;
            tests++; if (evt_id !== 3'd6) begin fails++; $display("FAIL merged_id: got %0d want 6", evt_id); end
         end
      end
      tests++; if (n !== 1) begin fails++; $display("FAIL merged_count: got %0d want 1", n); end
   endtask
   task automatic test_reset_mid;
      int n;
      reset = 1'b1;
      btn_in = 7'b0000001;
      evt_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      n = 0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (evt_valid) begin
            n++;
            tests++; if (evt_id !== 3'd0) begin fails++; $display("FAIL held_id: got %0d want 0", evt_id); end
         end
      end
      tests++; if (n !== 1) begin fails++; $display("FAIL held_count: got %0d want 1", n); end
      evt_ready = 1'b0;
      btn_in = 7'b0010001;
      repeat (2) @(negedge clk);
      tests++; if (evt_valid !== 1'b1 || evt_id !== 3'd4) begin fails++; $display("FAIL mid_offer: got valid=%b id=%0d want 1 4", evt_valid, evt_id); end
      reset = 1'b1;
      btn_in = 7'b1000000;
      @(negedge clk);
      tests++; if ({evt_valid, evt_id, pending, overrun} !== 12'd0) begin fails++; $display("FAIL mid_reset: got %b want 0", {evt_valid, evt_id, pending, overrun}); end
      btn_in = '0;
      @(negedge clk);
      reset = 1'b0;
      evt_ready = 1'b1;
      n = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         n += int'(evt_valid);
      end
      tests++; if (n !== 0) begin fails++; $display("FAIL post_reset_quiet: got %0d events want 0", n); end
   endtask
   task automatic test_same_cycle;
      int n;
      do_reset();
      btn_in = 7'b1000000;
      @(negedge clk);
      btn_in = '0;
      @(negedge clk);
      btn_in = 7'b0000100;
      @(negedge clk);
      btn_in = '0;
      evt_ready = 1'b1;
      repeat (5) @(negedge clk);
      btn_in = 7'b0000100;
      @(negedge clk);
      btn_in = '0;
      tests++; if (evt_valid !== 1'b1 || evt_id !== 3'd2) begin fails++; $display("FAIL same_grant: got valid=%b id=%0d want 1 2", evt_valid, evt_id); end
      tests++; if (pending !== 7'b0000100 || overrun !== 1'b0) begin fails++; $display("FAIL same_set_wins: got pending=%b overrun=%b want 0000100 0", pending, overrun); end
      n = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (evt_valid) begin
            n++;
            tests++; if (evt_id !== 3'd2) begin fails++; $display("FAIL same_second_id: got %0d want 2", evt_id); end
         end
      end
      tests++; if (n !== 1) begin fails++; $display("FAIL same_second_count: got %0d want 1", n); end
   endtask
   initial begin
      test_reset();
      test_single();
      test_order();
      test_wrap();
      test_back_pressure();
      test_reset_mid();
      test_same_cycle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
